div_job_sequencer: RTL and testbench
====================================

// Module: div_job_sequencer
// PURPOSE
//  Upstream feeder for the fixed-point divider (Mivider). Accepts A/B operand pairs on a
//  valid/ready stream and buffers them in a small FIFO. Issues one job at a time to the
//  divider and captures its quotient. Returns results on a valid/ready stream.
//  Handles divide-by-zero locally and recovers a hung divider via timeout plus sclr.
// PARAMETERS
//  W          10   operand/quotient width (divider A_in/B_in/Q_out width)
//  FIFO_DEPTH 4    operand FIFO entries (power of 2, >=2)
//  TIMEOUT    64   max WAIT cycles for div_valid before abort (>=2)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair present
//  in_ready   out  1   = !fifo_full; push when in_valid&&in_ready
//  in_a       in   W   dividend
//  in_b       in   W   divisor
//  div_start  out  1   one-cycle start pulse to divider
//  div_sclr   out  1   one-cycle synchronous clear to divider (timeout recovery)
//  div_a      out  W   registered dividend, stable from div_start until job ends
//  div_b      out  W   registered divisor, same
//  div_busy   in   1   divider busy
//  div_valid  in   1   divider result strobe
//  div_q      in   W   divider quotient, sampled when div_valid
//  out_valid  out  1   result held until out_ready
//  out_ready  in   1   consumer accepts result
//  out_q      out  W   quotient
//  out_dz     out  1   result is divide-by-zero saturation
//  out_to     out  1   result is timeout abort
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, state IDLE, timer 0; all outputs 0 except in_ready=1.
//  FIFO: registered, no bypass; an entry pushed at cycle T is first poppable at T+1.
//   Push and pop in the same cycle are both honoured. No push when full.
//  Output reg: loaded only when out_valid=0. out_valid drops the cycle after
//   out_valid&&out_ready. out_q/out_dz/out_to are stable while out_valid=1.
//  FSM:
//   IDLE: pop when fifo nonempty && !out_valid && !div_busy.
//    b==0  -> load out_q={W{1'b1}}, out_dz=1, out_valid=1; stay IDLE; divider untouched.
//    b!=0  -> latch div_a/div_b; go ISSUE.
//   ISSUE: div_start=1 for exactly this cycle. Clear timer. Go WAIT.
//   WAIT: timer+1 per cycle.
//    div_valid -> out_q=div_q, out_dz=0, out_to=0, out_valid=1 next cycle; go IDLE.
//    else if timer==TIMEOUT-1 -> div_sclr=1 this cycle; out_q=0, out_to=1, out_valid=1; go IDLE.
//    div_valid and the timeout condition in the same cycle: div_valid wins, no sclr.
//  div_valid outside WAIT is ignored (stale/spurious).
//  Latency: pop at T -> div_start at T+1 -> div_valid at V -> out_valid at V+1.
//   Divide-by-zero: pop at T -> out_valid at T+1.
//  Exactly one divider job in flight. Results return in input order.
//  Async reset mid-job: drops the job and FIFO contents. Divider is not sclr'd; the
//   IDLE div_busy gate covers any residual busy.
// STRUCTURE
//  Package div_seq_pkg: state enum {IDLE,ISSUE,WAIT}, SAT_Q={W{1'b1}} helper,
//   timer width function clog2(TIMEOUT).
//  Sub-module seq_fifo (W*2 data, FIFO_DEPTH, async rst_n, full/empty flags).
//  Top holds FSM, timer, operand and output registers.
// TESTING (bench divider stub: integer a/b after L=12 cycles, busy high start+1..valid)
//  1. A=64,B=32, out_ready=1 -> div_start 1 cycle after pop; out_q=2 at valid+1; dz=to=0.
//  2. Push 6 pairs back-to-back (64/32,100/10,9/3,50/5,7/7,81/9) with out_ready=1 ->
//     in_ready low after 4 queued; outputs in order 2,10,3,10,1,9; one job in flight.
//  3. A=5,B=0 -> no div_start; out_q=10'h3FF, out_dz=1 one cycle after pop.
//  4. Stub never asserts valid -> div_sclr pulse at WAIT cycle 64; out_q=0, out_to=1.
//     Next job (64/32) -> 2.
//  5. out_ready=0 for 20 cycles with 3 jobs queued -> first result held stable; no new
//     div_start until accepted; then results 2,10,3.
//  6. rst_n low during WAIT -> all outputs 0, in_ready=1 immediately. Late stub
//     div_valid ignored; next job correct.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the divider job sequencer.
// Holds the FSM state encoding and the sizing and saturation helpers.
package div_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  // Bits needed to count 0..timeout-1.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  // All-ones quotient returned for divide-by-zero.
  function automatic logic [63:0] sat_mask(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Registered operand FIFO with no bypass.
// A simultaneous push and pop are both honoured; a push while full is dropped.
module seq_fifo #(
  parameter int unsigned DataWidth = 20,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Extra MSB on each pointer separates full from empty.
  logic [PtrW:0]          wptr_q, rptr_q;
  logic [DataWidth-1:0]   mem_q [Depth];
  logic                   push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/div_job_sequencer.sv
// Feeds operand pairs to the divider one job at a time and returns quotients in order.
// Divide-by-zero is answered locally; a divider that never responds is cleared and aborted.
module div_job_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned W          = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         div_start,
  output logic         div_sclr,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic [W-1:0] div_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic         out_dz,
  output logic         out_to
);

  localparam int unsigned  TW        = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  SatQ      = W'(sat_mask(W));

  state_e         state_q;
  logic [TW-1:0]  timer_q;
  logic           start_q, ov_q, dz_q, to_q;
  logic [W-1:0]   a_q, b_q, q_q;

  logic           fifo_full, fifo_empty, pop, timeout_hit;
  logic [2*W-1:0] fifo_rdata;
  logic [W-1:0]   head_a, head_b;

  seq_fifo #(
    .DataWidth(2 * W),
    .Depth    (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (in_valid),
    .wdata_i({in_a, in_b}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign head_a = fifo_rdata[2*W-1:W];
  assign head_b = fifo_rdata[W-1:0];

  // Holding off on div_busy also covers a job left running by a reset.
  assign pop         = (state_q == StIdle) && !fifo_empty && !ov_q && !div_busy;
  assign timeout_hit = (state_q == StWait) && !div_valid && (timer_q == TimerLast);

  assign in_ready  = !fifo_full;
  assign div_sclr  = timeout_hit;
  assign div_start = start_q;
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign out_valid = ov_q;
  assign out_q     = q_q;
  assign out_dz    = dz_q;
  assign out_to    = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (ov_q && out_ready) ov_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            if (head_b == '0) begin
              ov_q <= 1'b1;
              q_q  <= SatQ;
              dz_q <= 1'b1;
              to_q <= 1'b0;
            end else begin
              a_q     <= head_a;
              b_q     <= head_b;
              start_q <= 1'b1;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          timer_q <= timer_q + 1'b1;
          if (div_valid) begin
            ov_q    <= 1'b1;
            q_q     <= div_q;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            state_q <= StIdle;
          end else if (timeout_hit) begin
            ov_q    <= 1'b1;
            q_q     <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Scoreboard bench for div_job_sequencer with a fixed-latency divider stub.
module tb_div_job_sequencer;

  localparam int unsigned W  = 10;
  localparam int          L  = 12;
  localparam int          TO = 64;

  typedef logic [W+1:0] res_t;  // {to, dz, q}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         div_start, div_sclr;
  logic [W-1:0] div_a, div_b;
  logic         div_busy, div_valid;
  logic [W-1:0] div_q;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_q;
  logic         out_dz, out_to;

  always #5 clk = ~clk;

  div_job_sequencer #(
    .W         (W),
    .FIFO_DEPTH(4),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .div_start(div_start),
    .div_sclr (div_sclr),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_busy (div_busy),
    .div_valid(div_valid),
    .div_q    (div_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_dz   (out_dz),
    .out_to   (out_to)
  );

  // Divider stub: busy from start+1, valid L cycles after start unless hung.
  int           cyc = 0;
  bit           hang = 1'b0;
  logic         stub_active = 1'b0;
  int           stub_cnt = 0;
  logic [W-1:0] stub_a = '0;
  logic [W-1:0] stub_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (div_sclr) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
    end else if (div_start) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      stub_a      <= div_a;
      stub_b      <= div_b;
    end else if (stub_active) begin
      if (stub_cnt == L && !hang) begin
        stub_active <= 1'b0;
        stub_cnt    <= 0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  assign div_busy  = stub_active;
  assign div_valid = stub_active && (stub_cnt == L) && !hang;
  assign div_q     = (stub_b != '0) ? stub_a / stub_b : '0;

  int   n_tests = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   push_cyc = 0, start_cyc = 0, rise_cyc = 0;
  int   n_start = 0, n_sclr = 0, n_full = 0;
  logic prev_ov = 1'b0;
  res_t hold_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_t expect_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {2'b01, {W{1'b1}}};
    return {2'b00, W'(a / b)};
  endfunction

  task automatic monitor();
    res_t cur, e;
    forever begin
      @(negedge clk);
      cur = {out_to, out_dz, out_q};
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) push_cyc = cyc;
        if (!in_ready) n_full++;
        if (div_start) begin
          start_cyc = cyc;
          n_start++;
          check_eq("one_job", 32'(stub_active), 32'd0);
          check_eq("start_while_held", 32'(out_valid), 32'd0);
        end
        if (div_sclr) begin
          n_sclr++;
          check_eq("sclr_latency", cyc - start_cyc, TO);
        end
        if (out_valid && !prev_ov) rise_cyc = cyc;
        if (out_valid && prev_ov) check_eq("held_stable", 32'(cur), 32'(hold_r));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_eq("result", 32'(cur), 32'(e));
          end
        end
        prev_ov = out_valid;
        hold_r  = cur;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    bit acc = 1'b0;
    int i = 0;
    exp_q.push_back(e);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!acc && i < 2000) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      i++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    int i = 0;
    while (!done && i < budget) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      i++;
    end
    if (!done) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int s0, t0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_flags", 32'({out_valid, div_start, div_sclr, out_dz, out_to}), 32'd0);
    check_eq("rst_data", 32'({div_a, div_b, out_q}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single job and its latencies
    send(10'd64, 10'd32, expect_div(10'd64, 10'd32));
    drain(200);
    check_eq("start_latency", start_cyc - push_cyc, 32'd2);
    check_eq("result_latency", rise_cyc - start_cyc, L + 1);

    // 2: back-to-back burst fills the FIFO
    s0 = n_start;
    t0 = n_full;
    send(10'd64, 10'd32, expect_div(10'd64, 10'd32));
    send(10'd100, 10'd10, expect_div(10'd100, 10'd10));
    send(10'd9, 10'd3, expect_div(10'd9, 10'd3));
    send(10'd50, 10'd5, expect_div(10'd50, 10'd5));
    send(10'd7, 10'd7, expect_div(10'd7, 10'd7));
    send(10'd81, 10'd9, expect_div(10'd81, 10'd9));
    drain(600);
    check_eq("fifo_went_full", 32'(n_full > t0), 32'd1);
    check_eq("burst_starts", n_start - s0, 32'd6);

    // 3: divide by zero answered locally
    s0 = n_start;
    send(10'd5, 10'd0, {2'b01, 10'h3FF});
    drain(50);
    check_eq("dz_no_start", n_start - s0, 32'd0);
    check_eq("dz_latency", rise_cyc - push_cyc, 32'd2);

    // 4: hung divider, then recovery
    s0   = n_sclr;
    hang = 1'b1;
    send(10'd64, 10'd32, {2'b10, 10'd0});
    drain(300);
    hang = 1'b0;
    check_eq("sclr_count", n_sclr - s0, 32'd1);
    send(10'd64, 10'd32, expect_div(10'd64, 10'd32));
    drain(200);

    // 5: consumer stalls with three jobs queued
    out_ready = 1'b0;
    s0 = n_start;
    send(10'd64, 10'd32, expect_div(10'd64, 10'd32));
    send(10'd100, 10'd10, expect_div(10'd100, 10'd10));
    send(10'd9, 10'd3, expect_div(10'd9, 10'd3));
    repeat (20) @(posedge clk);
    #1;
    check_eq("stall_held", 32'({out_valid, out_q}), 32'({1'b1, 10'd2}));
    check_eq("stall_one_start", n_start - s0, 32'd1);
    out_ready = 1'b1;
    drain(300);

    // 6: reset while the divider is working
    s0 = n_start;
    send(10'd64, 10'd32, expect_div(10'd64, 10'd32));
    for (int i = 0; i < 50 && n_start == s0; i++) @(posedge clk);
    check_eq("pre_reset_start", n_start - s0, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_flags", 32'({out_valid, div_start, div_sclr, out_dz, out_to}), 32'd0);
    check_eq("arst_data", 32'({div_a, div_b, out_q}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(10'd81, 10'd9, expect_div(10'd81, 10'd9));
    drain(300);
    check_eq("post_reset_idle", 32'(stub_active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
